// File: rtl/store_write_buffer_pkg.sv
// Shared store-path types: funct3 store codes, lane geometry, and the aligned-write record.
package store_write_buffer_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int OFF_W  = 2;

  typedef enum logic [2:0] {
    FUNCT3_SB = 3'b000,
    FUNCT3_SH = 3'b001,
    FUNCT3_SW = 3'b010
  } st_funct3_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } wr_lane_t;

  function automatic logic [BE_W-1:0] byte_be(input logic [OFF_W-1:0] off);
    return BE_W'(1) << off;
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store aligner: replicates byte/half data across lanes and builds the byte mask.
// Also flags SH/SW addresses that are not naturally aligned.
module store_align
  import store_write_buffer_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [DATA_W-1:0] i_data,
  output wr_lane_t          o_lane,
  output logic              o_valid_op,
  output logic              o_misalign
);

  always_comb begin
    o_lane     = '0;
    o_valid_op = 1'b0;
    o_misalign = 1'b0;
    case (i_funct3)
      FUNCT3_SB: begin
        o_lane.data = {4{i_data[7:0]}};
        o_lane.be   = byte_be(i_offset);
        o_valid_op  = 1'b1;
      end
      FUNCT3_SH: begin
        o_lane.data = {2{i_data[15:0]}};
        o_lane.be   = i_offset[1] ? 4'b1100 : 4'b0011;
        o_valid_op  = 1'b1;
        o_misalign  = i_offset[0];
      end
      FUNCT3_SW: begin
        o_lane.data = i_data;
        o_lane.be   = 4'b1111;
        o_valid_op  = 1'b1;
        o_misalign  = (i_offset != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: aligns SB/SH/SW stores and queues them in a DEPTH-entry FIFO toward the D-cache.
// Optional STORE_MISALIGN_TRAP_EN drops misaligned SH/SW and pulses st_misalign one cycle later.
module store_write_buffer
  import store_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [2:0]                 st_funct3,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  output logic                       st_misalign,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic [BE_W-1:0]            wr_be,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  wr_lane_t           w_lane;
  logic               w_valid_op;
  logic               w_misalign;
  logic               w_trap;
  logic               w_push;
  logic               w_pop;
  logic               w_enq;

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ADDR_W-1:0]  r_addr [DEPTH];
  wr_lane_t           r_lane [DEPTH];

  store_align u_align (
    .i_funct3   (st_funct3),
    .i_offset   (st_addr[OFF_W-1:0]),
    .i_data     (st_data),
    .o_lane     (w_lane),
    .o_valid_op (w_valid_op),
    .o_misalign (w_misalign)
  );

`ifdef STORE_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
  logic r_misalign;

  always_ff @(posedge clock) begin
    if (!reset) r_misalign <= 1'b0;
    else        r_misalign <= w_push && w_misalign;
  end

  assign st_misalign = r_misalign;
`else
  localparam bit TRAP_EN = 1'b0;
  assign st_misalign = 1'b0;
`endif

  // Full blocks the push even when a pop happens in the same cycle.
  assign st_ready = (r_count != FULL_CNT);
  assign empty    = (r_count == '0);
  assign wr_valid = !empty;
  assign w_push   = st_valid && st_ready;
  assign w_pop    = wr_valid && wr_ready;
  assign w_trap   = TRAP_EN && w_misalign;
  assign w_enq    = w_push && w_valid_op && !w_trap;

  assign wr_addr  = wr_valid ? r_addr[r_rd_ptr]      : '0;
  assign wr_data  = wr_valid ? r_lane[r_rd_ptr].data : '0;
  assign wr_be    = wr_valid ? r_lane[r_rd_ptr].be   : '0;
  assign count    = r_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_lane[i] <= '0;
      end
    end else begin
      if (w_enq) begin
        r_addr[r_wr_ptr] <= {st_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        r_lane[r_wr_ptr] <= w_lane;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: vector table, hand-written corner sequences, and random traffic
// compared every cycle against a queue-based model of the buffer.
module tb_store_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
`ifdef STORE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        st_valid = 1'b0;
  logic        wr_ready = 1'b0;
  logic [2:0]  st_funct3 = 3'd0;
  logic [31:0] st_addr = 32'd0;
  logic [31:0] st_data = 32'd0;
  logic        st_ready, st_misalign, wr_valid, empty;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_be;
  logic [2:0]  count;

  int n_pass = 0;
  int n_checks = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ea;
    logic [31:0] ed;
    logic [3:0]  eb;
    bit          misal;
    bit          bad;
  } vec_t;

  ent_t q[$];
  bit   exp_mis = 1'b0;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_funct3   (st_funct3),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_misalign (st_misalign),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .count       (count),
    .empty       (empty)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic bit is_valid_op(input logic [2:0] f);
    return f <= 3'd2;
  endfunction

  function automatic bit is_mis(input logic [2:0] f, input logic [31:0] a);
    return (f == 3'd1 && a[0]) || (f == 3'd2 && a[1:0] != 2'b00);
  endfunction

  // Expected cache write computed arithmetically from the store rules.
  function automatic ent_t mk(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    int   off;
    off    = int'(a[1:0]);
    e.addr = a & 32'hFFFF_FFFC;
    e.data = 32'd0;
    e.be   = 4'd0;
    if (f == 3'd0) begin
      e.data = {24'd0, d[7:0]} * 32'h0101_0101;
      e.be   = 4'(1 << off);
    end else if (f == 3'd1) begin
      e.data = {16'd0, d[15:0]} * 32'h0001_0001;
      e.be   = (off >= 2) ? 4'b1100 : 4'b0011;
    end else if (f == 3'd2) begin
      e.data = d;
      e.be   = 4'b1111;
    end
    return e;
  endfunction

  task automatic compare_model();
    ent_t h;
    bit   ne;
    ne = (q.size() != 0);
    h.addr = 32'd0; h.data = 32'd0; h.be = 4'd0;
    if (ne) h = q[0];
    chk("m_count",    64'(count),       64'(q.size()));
    chk("m_empty",    64'(empty),       64'(!ne));
    chk("m_wr_valid", 64'(wr_valid),    64'(ne));
    chk("m_st_ready", 64'(st_ready),    64'(q.size() != DEPTH));
    chk("m_wr_addr",  64'(wr_addr),     64'(h.addr));
    chk("m_wr_data",  64'(wr_data),     64'(h.data));
    chk("m_wr_be",    64'(wr_be),       64'(h.be));
    chk("m_misalign", 64'(st_misalign), 64'(exp_mis));
  endtask

  task automatic tick();
    bit   push, pop, valid, mis;
    ent_t e;
    push  = reset && st_valid && (q.size() != DEPTH);
    pop   = reset && (q.size() != 0) && wr_ready;
    valid = is_valid_op(st_funct3);
    mis   = is_mis(st_funct3, st_addr);
    e     = mk(st_funct3, st_addr, st_data);
    @(posedge clock);
    #1;
    if (!reset) begin
      q.delete();
      exp_mis = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      exp_mis = push && TRAP && mis;
      if (push && valid && !(TRAP && mis)) q.push_back(e);
    end
    compare_model();
  endtask

  task automatic drive(input bit v, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, input bit rdy);
    st_valid  = v;
    st_funct3 = f;
    st_addr   = a;
    st_data   = d;
    wr_ready  = rdy;
  endtask

  vec_t vt[11];

  initial begin
    logic [31:0] r_a, r_d;
    bit          enq;

    vt[0]  = '{3'd0, 32'h1003, 32'hAABBCC5A, 32'h1000, 32'h5A5A5A5A, 4'b1000, 1'b0, 1'b0};
    vt[1]  = '{3'd0, 32'h4001, 32'h00000077, 32'h4000, 32'h77777777, 4'b0010, 1'b0, 1'b0};
    vt[2]  = '{3'd0, 32'h6002, 32'h123456C3, 32'h6000, 32'hC3C3C3C3, 4'b0100, 1'b0, 1'b0};
    vt[3]  = '{3'd0, 32'h6000, 32'h00000011, 32'h6000, 32'h11111111, 4'b0001, 1'b0, 1'b0};
    vt[4]  = '{3'd1, 32'h2002, 32'h1234BEEF, 32'h2000, 32'hBEEFBEEF, 4'b1100, 1'b0, 1'b0};
    vt[5]  = '{3'd1, 32'h5000, 32'hFFFF1357, 32'h5000, 32'h13571357, 4'b0011, 1'b0, 1'b0};
    vt[6]  = '{3'd2, 32'h2004, 32'hDEADBEEF, 32'h2004, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0};
    vt[7]  = '{3'd2, 32'h3002, 32'hCAFEF00D, 32'h3000, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b0};
    vt[8]  = '{3'd1, 32'h7001, 32'h0000ABCD, 32'h7000, 32'hABCDABCD, 4'b0011, 1'b1, 1'b0};
    vt[9]  = '{3'd3, 32'h9000, 32'h12345678, 32'h0,    32'h0,        4'b0000, 1'b0, 1'b1};
    vt[10] = '{3'd7, 32'h9004, 32'h87654321, 32'h0,    32'h0,        4'b0000, 1'b0, 1'b1};

    // Reset held with a store offered: nothing may be captured.
    reset = 1'b0;
    drive(1'b1, 3'd2, 32'h100, 32'h1111_2222, 1'b1);
    tick();
    tick();
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_empty",    64'(empty),    64'd1);
    chk("rst_wr_be",    64'(wr_be),    64'd0);
    reset = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    tick();
    chk("rst_release_count", 64'(count), 64'd0);

    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vt[i].f, vt[i].a, vt[i].d, 1'b0);
      chk($sformatf("vec%0d_no_bypass", i), 64'(wr_valid), 64'd0);
      chk($sformatf("vec%0d_ready", i), 64'(st_ready), 64'd1);
      tick();
      drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      enq = !vt[i].bad && !(TRAP && vt[i].misal);
      chk($sformatf("vec%0d_misalign", i), 64'(st_misalign), 64'(TRAP && vt[i].misal));
      if (enq) begin
        chk($sformatf("vec%0d_count", i), 64'(count),   64'd1);
        chk($sformatf("vec%0d_addr", i),  64'(wr_addr), 64'(vt[i].ea));
        chk($sformatf("vec%0d_data", i),  64'(wr_data), 64'(vt[i].ed));
        chk($sformatf("vec%0d_be", i),    64'(wr_be),   64'(vt[i].eb));
      end else begin
        chk($sformatf("vec%0d_no_entry", i), 64'(count), 64'd0);
      end
      wr_ready = 1'b1;
      tick();
      chk($sformatf("vec%0d_drained", i), 64'(empty), 64'd1);
      chk($sformatf("vec%0d_pulse_end", i), 64'(st_misalign), 64'd0);
    end

    // SH then SW back to back while the cache accepts every cycle.
    drive(1'b1, 3'd1, 32'h2002, 32'h1234BEEF, 1'b1);
    tick();
    chk("shsw_sh_addr", 64'(wr_addr), 64'h2000);
    chk("shsw_sh_data", 64'(wr_data), 64'hBEEFBEEF);
    chk("shsw_sh_be",   64'(wr_be),   64'hC);
    drive(1'b1, 3'd2, 32'h2004, 32'hDEADBEEF, 1'b1);
    tick();
    chk("shsw_sw_addr",  64'(wr_addr), 64'h2004);
    chk("shsw_sw_data",  64'(wr_data), 64'hDEADBEEF);
    chk("shsw_sw_be",    64'(wr_be),   64'hF);
    chk("shsw_sw_count", 64'(count),   64'd1);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    tick();
    chk("shsw_empty", 64'(empty), 64'd1);

    // Fill to full under backpressure, then a single pop frees one slot.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd2, 32'h8000 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 1'b0);
      tick();
    end
    chk("full_count", 64'(count),    64'd4);
    chk("full_ready", 64'(st_ready), 64'd0);
    drive(1'b1, 3'd2, 32'h8010, 32'hC0DE0004, 1'b0);
    tick();
    chk("stall_count",     64'(count),   64'd4);
    chk("stall_head_addr", 64'(wr_addr), 64'h8000);
    chk("stall_head_data", 64'(wr_data), 64'hC0DE0000);
    wr_ready = 1'b1;
    tick();
    chk("pop_full_count", 64'(count),    64'd3);
    chk("pop_full_ready", 64'(st_ready), 64'd1);
    chk("pop_full_head",  64'(wr_addr),  64'h8004);
    wr_ready = 1'b0;
    tick();
    chk("fifth_accepted", 64'(count), 64'd4);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_order%0d", k), 64'(wr_data), 64'(32'hC0DE0001 + 32'(k)));
      tick();
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // Reset in the middle of a drain throws away everything.
    drive(1'b1, 3'd0, 32'hA001, 32'h55, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    tick();
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_addr",  64'(wr_addr), 64'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_after", 64'(wr_valid), 64'd0);

    // Simultaneous push and pop at count 2 keeps the level constant.
    drive(1'b1, 3'd2, 32'hB000, 32'h1, 1'b0);
    tick();
    drive(1'b1, 3'd2, 32'hB004, 32'h2, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      r_a = $urandom;
      r_d = $urandom;
      drive(1'b1, 3'd2, {r_a[31:2], 2'b00}, r_d, 1'b1);
      tick();
      chk($sformatf("pushpop%0d_count", i), 64'(count), 64'd2);
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    tick();
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r_a = $urandom;
      r_d = $urandom;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 4)), r_a, r_d,
            $urandom_range(0, 1) == 1);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
